// File: rtl/v2f_seq_divmod.sv
// ----------------------------------------------------------------------------
// v2f_seq_divmod
//   Multi-cycle restoring divider that produces one quotient bit per cycle.
//   It is used where a single-cycle divide/modulo chain would be too costly.
//   Truncation is toward zero. The remainder takes the sign of the dividend.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//   SIGNED 1 = two's-complement operands/results, 0 = unsigned
//
// Ports
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   START  request, sampled only while idle (A and B are captured with it)
//   A, B   dividend, divisor
//   BUSY   operation in progress (FSM outside IDLE)
//   DONE   one-cycle pulse: Q, R and DIV0 are valid
//   Q, R   quotient, remainder (held until the next DONE)
//   DIV0   last operation had B == 0
// ----------------------------------------------------------------------------
module v2f_seq_divmod #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV0
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    // Dividend magnitude shifts out of the top while quotient bits shift in at
    // the bottom, so after WIDTH iterations this register holds the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    // The stored remainder is always below the divisor, so WIDTH bits suffice.
    // The shifted trial value below carries the extra bit.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] a_raw;
    logic             a_neg;
    logic             b_neg;
    logic             div0_pend;
    logic [CW-1:0]    cnt;

    logic             a_in_neg;
    logic             b_in_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), otherwise a latch is inferred.
    always_comb begin
        a_in_neg  = (SIGNED != 0) && A[WIDTH-1];
        b_in_neg  = (SIGNED != 0) && B[WIDTH-1];
        // The magnitude of the most negative value is 2**(WIDTH-1). It is
        // exact when read as an unsigned WIDTH-bit number, so the negation
        // cannot overflow.
        a_abs     = a_in_neg ? -A : A;
        b_abs     = b_in_neg ? -B : B;

        rem_shift = {rem, dvd[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dvs});
        // Only used when fits=1. The true difference is then below dvs, so the
        // low WIDTH bits are exact.
        rem_sub   = rem_shift[WIDTH-1:0] - dvs;

        // For min / -1 the magnitude quotient is 2**(WIDTH-1) with no sign
        // flip. This gives Q = A (wrapped) and R = 0.
        q_fix     = (a_neg ^ b_neg) ? -dvd : dvd;
        r_fix     = a_neg ? -rem : rem;
    end

    assign BUSY = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            a_raw     <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            div0_pend <= 1'b0;
            cnt       <= '0;
            DONE      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DIV0      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_raw <= A;
                        a_neg <= a_in_neg;
                        b_neg <= b_in_neg;
                        if (B == '0) begin
                            div0_pend <= 1'b1;
                            state     <= S_FIX;
                        end else begin
                            div0_pend <= 1'b0;
                            dvd       <= a_abs;
                            dvs       <= b_abs;
                            rem       <= '0;
                            cnt       <= '0;
                            state     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= fits ? rem_sub : rem_shift[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div0_pend) begin
                        Q    <= '1;
                        R    <= a_raw;
                        DIV0 <= 1'b1;
                    end else begin
                        Q    <= q_fix;
                        R    <= r_fix;
                        DIV0 <= 1'b0;
                    end
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// ----------------------------------------------------------------------------
// tb_v2f_seq_divmod
//   Testbench for v2f_seq_divmod with six instances: WIDTH {8, 2, 32} x
//   SIGNED {0, 1}. Expected results come from a reference model that uses
//   the language's own / and % on 64-bit integers.
// ----------------------------------------------------------------------------
module tb_v2f_seq_divmod;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [5:0] start_v = '0;
    wire  [5:0] busy_v;
    wire  [5:0] done_v;
    wire  [5:0] div0_v;

    // id 0: W8 unsigned, 1: W8 signed, 2: W2 unsigned, 3: W2 signed,
    // id 4: W32 unsigned, 5: W32 signed
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  a2 = '0, b2 = '0, a3 = '0, b3 = '0;
    logic [31:0] a4 = '0, b4 = '0, a5 = '0, b5 = '0;
    wire  [7:0]  q0, r0, q1, r1;
    wire  [1:0]  q2, r2, q3, r3;
    wire  [31:0] q4, r4, q5, r5;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    v2f_seq_divmod #(.WIDTH(8),  .SIGNED(0)) u_u8  (.CLK(CLK), .RST_N(RST_N), .START(start_v[0]), .A(a0), .B(b0),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .Q(q0), .R(r0), .DIV0(div0_v[0]));
    v2f_seq_divmod #(.WIDTH(8),  .SIGNED(1)) u_s8  (.CLK(CLK), .RST_N(RST_N), .START(start_v[1]), .A(a1), .B(b1),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .Q(q1), .R(r1), .DIV0(div0_v[1]));
    v2f_seq_divmod #(.WIDTH(2),  .SIGNED(0)) u_u2  (.CLK(CLK), .RST_N(RST_N), .START(start_v[2]), .A(a2), .B(b2),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .Q(q2), .R(r2), .DIV0(div0_v[2]));
    v2f_seq_divmod #(.WIDTH(2),  .SIGNED(1)) u_s2  (.CLK(CLK), .RST_N(RST_N), .START(start_v[3]), .A(a3), .B(b3),
        .BUSY(busy_v[3]), .DONE(done_v[3]), .Q(q3), .R(r3), .DIV0(div0_v[3]));
    v2f_seq_divmod #(.WIDTH(32), .SIGNED(0)) u_u32 (.CLK(CLK), .RST_N(RST_N), .START(start_v[4]), .A(a4), .B(b4),
        .BUSY(busy_v[4]), .DONE(done_v[4]), .Q(q4), .R(r4), .DIV0(div0_v[4]));
    v2f_seq_divmod #(.WIDTH(32), .SIGNED(1)) u_s32 (.CLK(CLK), .RST_N(RST_N), .START(start_v[5]), .A(a5), .B(b5),
        .BUSY(busy_v[5]), .DONE(done_v[5]), .Q(q5), .R(r5), .DIV0(div0_v[5]));

    function automatic int width_of(input int id);
        case (id)
            0, 1:    return 8;
            2, 3:    return 2;
            default: return 32;
        endcase
    endfunction

    function automatic bit signed_of(input int id);
        return (id % 2) == 1;
    endfunction

    function automatic logic [31:0] get_q(input int id);
        case (id)
            0:       return {24'd0, q0};
            1:       return {24'd0, q1};
            2:       return {30'd0, q2};
            3:       return {30'd0, q3};
            4:       return q4;
            default: return q5;
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int id);
        case (id)
            0:       return {24'd0, r0};
            1:       return {24'd0, r1};
            2:       return {30'd0, r2};
            3:       return {30'd0, r3};
            4:       return r4;
            default: return r5;
        endcase
    endfunction

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        case (id)
            0:       begin a0 = a[7:0]; b0 = b[7:0]; end
            1:       begin a1 = a[7:0]; b1 = b[7:0]; end
            2:       begin a2 = a[1:0]; b2 = b[1:0]; end
            3:       begin a3 = a[1:0]; b3 = b[1:0]; end
            4:       begin a4 = a;      b4 = b;      end
            default: begin a5 = a;      b5 = b;      end
        endcase
    endtask

    // Reference: Verilog / and % semantics on the interpreted operand values.
    task automatic model(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic d0);
        longint m, ua, ub, sa, sb;
        m  = (longint'(1) <<< w) - 1;
        ua = longint'({32'd0, a}) & m;
        ub = longint'({32'd0, b}) & m;
        if (ub == 0) begin
            q  = 32'(m);
            r  = 32'(ua);
            d0 = 1'b1;
        end else if (sg) begin
            sa = (ua >= (longint'(1) <<< (w - 1))) ? ua - (longint'(1) <<< w) : ua;
            sb = (ub >= (longint'(1) <<< (w - 1))) ? ub - (longint'(1) <<< w) : ub;
            q  = 32'((sa / sb) & m);
            r  = 32'((sa % sb) & m);
            d0 = 1'b0;
        end else begin
            q  = 32'(ua / ub);
            r  = 32'(ua % ub);
            d0 = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance id: result, latency, BUSY span, DONE width.
    task automatic op(input int id, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          w;
        int          lat;
        int          busy_n;
        int          exp_lat;
        bit          got;
        logic [31:0] eq, er;
        logic        ed;
        w = width_of(id);
        model(w, signed_of(id), a, b, eq, er, ed);
        exp_lat = ed ? 1 : w + 1;
        @(negedge CLK);
        set_ops(id, a, b);
        start_v[id] = 1'b1;
        @(posedge CLK);
        #1;
        start_v[id] = 1'b0;
        check($sformatf("%s busy_after_accept", tag), busy_v[id], 1);
        lat    = 0;
        busy_n = 1;
        got    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            #1;
            if (done_v[id]) begin
                lat = c;
                got = 1;
                break;
            end else if (busy_v[id]) begin
                busy_n++;
            end
        end
        check($sformatf("%s done_seen", tag), got, 1);
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s busy_cycles", tag), busy_n, exp_lat);
        check($sformatf("%s busy_at_done", tag), busy_v[id], 0);
        check($sformatf("%s q", tag), get_q(id), eq);
        check($sformatf("%s r", tag), get_r(id), er);
        check($sformatf("%s div0", tag), div0_v[id], ed);
        @(posedge CLK);
        #1;
        check($sformatf("%s done_one_cycle", tag), done_v[id], 0);
    endtask

    initial begin
        int          ndone;
        int          lat;
        int          sel;
        bit          seen_done;
        bit          prev_busy;
        logic [31:0] hq, hr, ra, rb, eq, er;
        logic        ed;
        logic [31:0] exp_q[$];
        logic [31:0] exp_r[$];
        logic        exp_d[$];

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int id = 0; id < 6; id++) begin
            check($sformatf("reset id%0d busy", id), busy_v[id], 0);
            check($sformatf("reset id%0d done", id), done_v[id], 0);
            check($sformatf("reset id%0d div0", id), div0_v[id], 0);
            check($sformatf("reset id%0d q", id), get_q(id), 0);
            check($sformatf("reset id%0d r", id), get_r(id), 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;

        // Directed cases
        op(0, 100, 7, "u8 100/7");
        op(1, 32'hF9, 2, "s8 -7/2");
        op(1, 7, 32'hFE, "s8 7/-2");
        op(0, 32'h55, 0, "u8 div0");
        op(0, 100, 7, "u8 div0_cleared");
        op(1, 32'h80, 32'hFF, "s8 min/-1");
        op(0, 255, 1, "u8 255/1");
        op(1, 32'h55, 0, "s8 div0");
        op(5, 32'h8000_0000, 32'hFFFF_FFFF, "s32 min/-1");
        op(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u32 max/max");

        // START pulses while busy are ignored
        @(negedge CLK);
        set_ops(0, 100, 7);
        start_v[0] = 1'b1;
        @(posedge CLK);
        #1;
        start_v[0] = 1'b0;
        ndone = 0;
        lat   = 0;
        hq    = '0;
        hr    = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3 || c == 5) begin
                set_ops(0, 200, 3);
                start_v[0] = 1'b1;
            end
            @(posedge CLK);
            #1;
            start_v[0] = 1'b0;
            if (done_v[0]) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    hq  = get_q(0);
                    hr  = get_r(0);
                end
            end
        end
        check("ignore_start done_count", ndone, 1);
        check("ignore_start latency", lat, 9);
        check("ignore_start q", hq, 14);
        check("ignore_start r", hr, 2);

        // START held high: each result uses the operands present at its accept edge
        ndone     = 0;
        prev_busy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            ra = $urandom_range(0, 255);
            rb = $urandom_range(1, 255);
            set_ops(0, ra, rb);
            start_v[0] = 1'b1;
            @(posedge CLK);
            #1;
            if (busy_v[0] && !prev_busy) begin
                model(8, 0, ra, rb, eq, er, ed);
                exp_q.push_back(eq);
                exp_r.push_back(er);
                exp_d.push_back(ed);
            end
            if (done_v[0]) begin
                check("held_start pending_op", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check($sformatf("held_start#%0d q", ndone), get_q(0), exp_q.pop_front());
                    check($sformatf("held_start#%0d r", ndone), get_r(0), exp_r.pop_front());
                    check($sformatf("held_start#%0d div0", ndone), div0_v[0], exp_d.pop_front());
                end
                ndone++;
            end
            prev_busy = busy_v[0];
            if (ndone == 3) break;
        end
        @(negedge CLK);
        start_v[0] = 1'b0;
        check("held_start done_count", ndone, 3);
        exp_q.delete();
        exp_r.delete();
        exp_d.delete();
        repeat (2) @(posedge CLK);

        // Reset mid-operation aborts immediately with no DONE
        op(0, 255, 2, "u8 pre_reset");
        @(negedge CLK);
        set_ops(0, 100, 7);
        start_v[0] = 1'b1;
        @(posedge CLK);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("abort busy", busy_v[0], 0);
        check("abort done", done_v[0], 0);
        check("abort q", get_q(0), 0);
        check("abort r", get_r(0), 0);
        check("abort div0", div0_v[0], 0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                @(negedge CLK);
                RST_N = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (done_v[0]) seen_done = 1;
        end
        check("abort no_done", seen_done, 0);
        op(0, 100, 7, "u8 after_reset");

        // Random sweep over every configuration
        for (int id = 0; id < 6; id++) begin
            for (int n = 0; n < 30; n++) begin
                ra  = $urandom;
                rb  = $urandom;
                sel = $urandom_range(0, 9);
                if (sel == 0) rb = 0;
                if (sel == 1) begin
                    ra = 32'd1 << (width_of(id) - 1);
                    rb = 32'hFFFF_FFFF;
                end
                if (sel == 2) rb = 1;
                op(id, ra, rb, $sformatf("rand id%0d n%0d", id, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
